// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data port arbiter in front of a single shared memory
module mem_port_arbiter #(
  parameter int unsigned B_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read_a,
  input  logic [15:0] mem_address_a,
  output logic [15:0] mem_rdata_a,
  output logic        mem_resp_a,
  input  logic        mem_read_b,
  input  logic        mem_write_b,
  input  logic [15:0] mem_address_b,
  input  logic [15:0] mem_wdata_b,
  input  logic [1:0]  mem_wmask_b,
  output logic [15:0] mem_rdata_b,
  output logic        mem_resp_b,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_wmask,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
);

  localparam int unsigned SW = $clog2(B_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(B_STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          pmem_read_q, pmem_read_d;
  logic          pmem_write_q, pmem_write_d;
  logic [15:0]   pmem_address_q, pmem_address_d;
  logic [15:0]   pmem_wdata_q, pmem_wdata_d;
  logic [1:0]    pmem_wmask_q, pmem_wmask_d;

  logic req_a;
  logic req_b;

  // A read+write pair on port B is malformed and treated as no request
  assign req_a = mem_read_a;
  assign req_b = mem_read_b ^ mem_write_b;

  // Arbitration, command capture, completion and fetch-starvation streak tracking
  always_comb begin
    state_d        = state_q;
    streak_d       = streak_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    pmem_wmask_d   = pmem_wmask_q;

    case (state_q)
      IDLE: begin
        if (req_b && !(req_a && streak_q >= STREAK_MAX)) begin
          state_d        = GRANT_B;
          pmem_read_d    = mem_read_b;
          pmem_write_d   = mem_write_b;
          pmem_address_d = mem_address_b;
          pmem_wdata_d   = mem_wdata_b;
          pmem_wmask_d   = mem_wmask_b;
          if (!req_a) begin
            streak_d = '0;
          end else if (streak_q < STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
          end
        end else if (req_a) begin
          state_d        = GRANT_A;
          pmem_read_d    = 1'b1;
          pmem_write_d   = 1'b0;
          pmem_address_d = mem_address_a;
          pmem_wdata_d   = 16'h0000;
          pmem_wmask_d   = 2'b11;
          streak_d       = '0;
        end
      end
      GRANT_A, GRANT_B: begin
        if (pmem_resp) begin
          state_d        = IDLE;
          pmem_read_d    = 1'b0;
          pmem_write_d   = 1'b0;
          pmem_address_d = 16'h0000;
          pmem_wdata_d   = 16'h0000;
          pmem_wmask_d   = 2'b11;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and command registers; reset abandons any in-flight transaction
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      streak_q       <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= 16'h0000;
      pmem_wdata_q   <= 16'h0000;
      pmem_wmask_q   <= 2'b11;
    end else begin
      state_q        <= state_d;
      streak_q       <= streak_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      pmem_wmask_q   <= pmem_wmask_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign pmem_wmask   = pmem_wmask_q;

  assign mem_resp_a  = (state_q == GRANT_A) && pmem_resp;
  assign mem_resp_b  = (state_q == GRANT_B) && pmem_resp;
  assign mem_rdata_a = pmem_rdata;
  assign mem_rdata_b = pmem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read_a;
  logic [15:0] mem_address_a;
  logic [15:0] mem_rdata_a;
  logic        mem_resp_a;
  logic        mem_read_b;
  logic        mem_write_b;
  logic [15:0] mem_address_b;
  logic [15:0] mem_wdata_b;
  logic [1:0]  mem_wmask_b;
  logic [15:0] mem_rdata_b;
  logic        mem_resp_b;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.B_STREAK_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_read_a(mem_read_a), .mem_address_a(mem_address_a),
    .mem_rdata_a(mem_rdata_a), .mem_resp_a(mem_resp_a),
    .mem_read_b(mem_read_b), .mem_write_b(mem_write_b),
    .mem_address_b(mem_address_b), .mem_wdata_b(mem_wdata_b),
    .mem_wmask_b(mem_wmask_b), .mem_rdata_b(mem_rdata_b), .mem_resp_b(mem_resp_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits at falling edges until a downstream command appears; a timeout counts as a failure
  task automatic wait_cmd(input string tag);
    int n;
    n = 0;
    while (!(pmem_read || pmem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(pmem_read || pmem_write)) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Drives a one-cycle pmem_resp now and returns the combinational responses seen
  task automatic pulse_resp(input logic [15:0] rd, output logic ra, output logic rb,
                            output logic [15:0] rda, output logic [15:0] rdb);
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    #1;
    ra  = mem_resp_a;
    rb  = mem_resp_b;
    rda = mem_rdata_a;
    rdb = mem_rdata_b;
    @(negedge clk);
    pmem_resp = 1'b0;
  endtask

  logic        ra, rb;
  logic [15:0] rda, rdb;
  string       order;
  int          busy;

  initial begin
    reset_n = 1'b0;
    mem_read_a = 1'b1; mem_address_a = 16'h1111;
    mem_read_b = 1'b1; mem_write_b = 1'b0;
    mem_address_b = 16'h2222; mem_wdata_b = 16'h3333; mem_wmask_b = 2'b01;
    pmem_rdata = 16'h0000; pmem_resp = 1'b1;

    // Reset with every request asserted
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_address", pmem_address, 16'h0000);
    chk("rst_pmem_wdata", pmem_wdata, 16'h0000);
    chk("rst_pmem_wmask", pmem_wmask, 2'b11);
    chk("rst_resp", {mem_resp_a, mem_resp_b}, 2'b00);
    mem_read_a = 1'b0; mem_read_b = 1'b0; pmem_resp = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_state", dut.state_q, 32'd0);

    // Response in IDLE is ignored
    pulse_resp(16'hDEAD, ra, rb, rda, rdb);
    chk("idle_resp", {ra, rb}, 2'b00);
    chk("idle_state", dut.state_q, 32'd0);

    // Lone fetch with two-cycle downstream latency
    mem_read_a = 1'b1; mem_address_a = 16'h3000;
    wait_cmd("fetch");
    chk("fetch_cmd", {pmem_read, pmem_write}, 2'b10);
    chk("fetch_addr", pmem_address, 16'h3000);
    chk("fetch_mask", pmem_wmask, 2'b11);
    #1;
    chk("fetch_noresp_early", mem_resp_a, 1'b0);
    repeat (2) @(negedge clk);
    pulse_resp(16'h1234, ra, rb, rda, rdb);
    mem_read_a = 1'b0;
    chk("fetch_resp", {ra, rb}, 2'b10);
    chk("fetch_rdata", rda, 16'h1234);
    chk("fetch_read_drop", pmem_read, 1'b0);
    #1;
    chk("fetch_single_pulse", mem_resp_a, 1'b0);

    // Byte store on B; address change mid-grant must not leak through
    mem_write_b = 1'b1; mem_address_b = 16'h4001;
    mem_wdata_b = 16'hAB00; mem_wmask_b = 2'b10;
    wait_cmd("store");
    chk("store_cmd", {pmem_read, pmem_write}, 2'b01);
    chk("store_wmask", pmem_wmask, 2'b10);
    chk("store_wdata", pmem_wdata, 16'hAB00);
    mem_address_b = 16'h5000;
    @(negedge clk);
    chk("store_addr_held", pmem_address, 16'h4001);
    pulse_resp(16'h0000, ra, rb, rda, rdb);
    mem_write_b = 1'b0;
    chk("store_resp", {ra, rb}, 2'b01);
    chk("store_wdata_clear", pmem_wdata, 16'h0000);

    // B read at minimum latency, data routed to port B
    mem_read_b = 1'b1; mem_address_b = 16'h0042;
    wait_cmd("bread");
    pulse_resp(16'h5A5A, ra, rb, rda, rdb);
    mem_read_b = 1'b0;
    chk("bread_resp", {ra, rb}, 2'b01);
    chk("bread_rdata", rdb, 16'h5A5A);

    // Continuous contention: four B grants then one A grant, repeated
    mem_read_a = 1'b1; mem_address_a = 16'h0A0A;
    mem_write_b = 1'b1; mem_address_b = 16'h0B0B; mem_wmask_b = 2'b11;
    order = "";
    for (int i = 0; i < 10; i++) begin
      wait_cmd("cont");
      if (pmem_read) begin
        order = {order, "A"};
        chk("cont_streak_clear", dut.streak_q, 32'd0);
      end else begin
        order = {order, "B"};
      end
      pulse_resp(16'h0000, ra, rb, rda, rdb);
    end
    mem_read_a = 1'b0; mem_write_b = 1'b0;
    checks++;
    if (order != "BBBBABBBBA") begin
      errors++;
      $display("FAIL cont_order got=%s exp=BBBBABBBBA", order);
    end

    // Malformed B request alone is never granted
    mem_read_b = 1'b1; mem_write_b = 1'b1;
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pmem_read || pmem_write) busy++;
    end
    chk("illegal_b_nogrant", busy, 0);
    mem_read_a = 1'b1; mem_address_a = 16'h0777;
    wait_cmd("illegal_a");
    chk("illegal_a_cmd", {pmem_read, pmem_write}, 2'b10);
    chk("illegal_a_addr", pmem_address, 16'h0777);
    pulse_resp(16'h0000, ra, rb, rda, rdb);
    mem_read_a = 1'b0; mem_read_b = 1'b0; mem_write_b = 1'b0;
    chk("illegal_a_resp", {ra, rb}, 2'b10);

    // Reset during a B grant abandons it
    mem_write_b = 1'b1; mem_address_b = 16'h0C0C; mem_wdata_b = 16'h00FF; mem_wmask_b = 2'b01;
    wait_cmd("abort");
    chk("abort_cmd", pmem_write, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_write_drop", pmem_write, 1'b0);
    pulse_resp(16'h0000, ra, rb, rda, rdb);
    chk("abort_no_resp", rb, 1'b0);
    reset_n = 1'b1;
    wait_cmd("after");
    chk("after_cmd", {pmem_read, pmem_write}, 2'b01);
    chk("after_addr", pmem_address, 16'h0C0C);
    pulse_resp(16'h0000, ra, rb, rda, rdb);
    mem_write_b = 1'b0;
    chk("after_resp", {ra, rb}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter between the pipeline's instruction-fetch port (port A, read-only) and the MEM-stage data port (port B, read/write with byte mask) in front of the single shared physical memory. Port B signals come straight from the MEM-stage memory-access block's `mem_*_b` outputs. Port A is the fetch stage's read port. The block latches the granted request, drives one downstream transaction at a time, and routes the response back to the winner. Port B has priority, with a streak limit that prevents fetch starvation.

## Interface
Parameters:
- `B_STREAK_MAX`, default 4: maximum consecutive B grants while A is waiting before A is forced through; legal range 1..15.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `reset_n`  in  1  synchronous, active-low reset, sampled on `clk`.
- `mem_read_a`  in  1  fetch read request; held until `mem_resp_a`.
- `mem_address_a`  in  16  fetch word address (lc3b_word).
- `mem_rdata_a`  out  16  fetch read data.
- `mem_resp_a`  out  1  fetch transaction complete.
- `mem_read_b` / `mem_write_b`  in  1 each  data request; held until `mem_resp_b`.
- `mem_address_b`  in  16  data address.
- `mem_wdata_b`  in  16  data write data.
- `mem_wmask_b`  in  2  byte-enable mask (lc3b_2bit).
- `mem_rdata_b`  out  16  data read data.
- `mem_resp_b`  out  1  data transaction complete.
- `pmem_read` / `pmem_write`  out  1 each  downstream command.
- `pmem_address`  out  16  downstream address.
- `pmem_wdata`  out  16  downstream write data.
- `pmem_wmask`  out  2  downstream byte mask.
- `pmem_rdata`  in  16  downstream read data.
- `pmem_resp`  in  1  downstream completion, one-cycle pulse.

## Operation
- States: IDLE, GRANT_A, GRANT_B.
- `req_a` = `mem_read_a`. `req_b` = `mem_read_b` XOR `mem_write_b`. Both read and write asserted on B counts as no request and is never granted.
- Arbitration in IDLE:
  - Only `req_a`: go to GRANT_A.
  - Only `req_b`: go to GRANT_B.
  - Both, and `streak` < `B_STREAK_MAX`: go to GRANT_B.
  - Both, and `streak` == `B_STREAK_MAX`: go to GRANT_A.
  - Neither: stay in IDLE.
- On every grant, register the winner's command into the `pmem_*` output registers:
  - A: read=1, write=0, wdata=0, wmask=2'b11.
  - B: its read/write, address, wdata, wmask as presented.
- `pmem_*` registers hold constant for the whole grant. Requester input changes mid-grant are ignored.
- In GRANT_x:
  - When `pmem_resp`=1: `mem_resp_x`=1 in the same cycle, combinationally. Next state is IDLE and the `pmem_*` command registers clear to the idle values.
  - Otherwise stay in GRANT_x.
- `mem_resp_a`=1 only in GRANT_A with `pmem_resp`. `mem_resp_b`=1 only in GRANT_B with `pmem_resp`. They are never both 1.
- `mem_rdata_a` = `mem_rdata_b` = `pmem_rdata` at all times. Requesters qualify the data with their own resp.
- `pmem_resp` seen in IDLE is ignored: no resp is forwarded and no state change occurs.
- Streak counter, width ceil(log2(`B_STREAK_MAX`+1)):
  - B grant while `req_a`=1: `streak` += 1, saturating at `B_STREAK_MAX`.
  - B grant while `req_a`=0: `streak` clears to 0.
  - Any A grant: `streak` clears to 0.
- Reset values: state=IDLE, `streak`=0, `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, `pmem_wmask`=2'b11, `mem_resp_a`=`mem_resp_b`=0.
- Reset mid-transaction abandons the transaction. No resp is forwarded, and `pmem_read`/`pmem_write` drop in the first cycle after the reset edge. The downstream memory tolerates an aborted command.

## Timing
- Request first seen in IDLE at edge N: grant registered at N, `pmem_*` valid from cycle N+1.
- Earliest `pmem_resp` is cycle N+1, giving `mem_resp_x` in cycle N+1. Minimum latency is 1 cycle after grant.
- After resp in cycle M: IDLE in cycle M+1, and the next grant is registered at the end of M+1. There is exactly one idle-bus cycle between transactions.
- No combinational path from `mem_*_a`/`mem_*_b` inputs to `pmem_*`. The only combinational paths are `pmem_resp` → `mem_resp_x` and `pmem_rdata` → `mem_rdata_x`.

## Test plan
- Reset: hold `reset_n`=0 with all requests high → all `pmem_*` at reset values, `mem_resp_a`=`mem_resp_b`=0, state IDLE after release.
- Lone fetch: `mem_read_a`=1, address x3000, downstream responds 2 cycles after `pmem_read` with rdata x1234 → `pmem_address`=x3000, `mem_resp_a` pulses once with `mem_rdata_a`=x1234, `pmem_read` low the next cycle.
- Byte store on B: write=1, address x4001, wdata xAB00, wmask 2'b10 → `pmem_write`=1, `pmem_wmask`=2'b10, `pmem_wdata`=xAB00. Changing `mem_address_b` to x5000 mid-grant leaves `pmem_address`=x4001.
- Contention with `B_STREAK_MAX`=4, both requesting continuously: grant order is B,B,B,B,A,B,B,B,B,A; `streak` returns to 0 after each A grant.
- Illegal B: `mem_read_b`=`mem_write_b`=1 with A idle → no grant for 10 cycles. With `req_a` also high → A granted.
- Reset mid-grant: `reset_n`=0 while in GRANT_B before `pmem_resp` → no `mem_resp_b`, `pmem_write`=0 the next cycle, and a fresh request after reset is served normally.
